fft_reorder_8p: RTL
===================

Name: fft_reorder_8p

Overview:
Output-side reorder buffer for the 8-point FFT datapath. It accepts FFT results arriving in bit-reversed index order and re-emits them in natural index order. It uses ping-pong banks so that streaming runs without bubbles. It sits between the last FFT butterfly stage and the downstream consumer, and provides valid/ready flow control on both sides.

Parameters:
DATA_WIDTH, 16, width of each real and imaginary component (signed)
N, 8, frame length in samples; must be a power of two >= 2; LOG2N = $clog2(N)
BYPASS, 0, 1 = write addresses in natural order (no reordering); buffering and handshakes unchanged

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  block can accept an input sample
s_re  in  DATA_WIDTH  input real part, signed
s_im  in  DATA_WIDTH  input imaginary part, signed
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts output sample
m_re  out  DATA_WIDTH  output real part, signed
m_im  out  DATA_WIDTH  output imaginary part, signed
m_last  out  1  high with output sample index N-1 of each frame

Behaviour:
- Reset: arst_n is asynchronous and active-low; clock is clk. Reset clears m_valid=0, m_last=0, m_re=0, m_im=0, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full[1:0]=0. Bank memory contents are not reset.
- Reset mid-frame discards any partially written bank and any undrained bank. The first sample accepted after reset is sample 0 of a new frame.
- Storage: 2 banks x N entries x 2*DATA_WIDTH, implemented as flops or distributed RAM with combinational read.
- Write side:
  - s_ready = !full[wr_bank], a combinational function of registered state only. It does not depend on s_valid.
  - On s_valid && s_ready: write mem[wr_bank][waddr], where waddr = bitrev(wr_cnt) if BYPASS=0, else wr_cnt. Then increment wr_cnt.
  - When wr_cnt == N-1 on a write: set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
- Read side (one output register stage):
  - load = full[rd_bank] && (!m_valid || m_ready).
  - On load: m_re/m_im <= mem[rd_bank][rd_cnt]; m_last <= (rd_cnt == N-1); m_valid <= 1; increment rd_cnt.
  - When rd_cnt == N-1 on a load: clear full[rd_bank], toggle rd_bank, and wrap rd_cnt to 0.
  - Else if m_ready: m_valid <= 0 and m_last <= 0.
  - While m_valid && !m_ready, m_re/m_im/m_last hold stable.
- Latency: the final write of a frame at edge E sets full at E. The first load occurs at E+1, so m_valid is high after E+1.
- Throughput: with m_ready held at 1 and s_valid held at 1, the block sustains 1 sample/cycle indefinitely. s_ready never drops, because the bank freed by the last load at the edge where the other bank completes is writable the next cycle.
- Simultaneous events:
  - A set and a clear of full in the same cycle always target different banks; both take effect.
  - The write side cannot set a full bank, and the read side cannot clear a non-full bank.
- Backpressure: if both banks are full, s_ready = 0 until the reader finishes draining rd_bank. No data is lost or overwritten.
- Arithmetic: pure data movement; no width change, rounding, or sign manipulation.

Test Plan:
- Reset then one frame with s_re = 0..7, s_im = 100..107, m_ready = 1 -> m_re = 0,4,2,6,1,5,3,7 and m_im = 100,104,102,106,101,105,103,107; m_last high only on the 8th output; first m_valid one cycle after the 8th input handshake.
- Four back-to-back frames (32 samples, s_valid = 1, m_ready = 1) -> s_ready constantly 1; 32 consecutive m_valid cycles with no gaps; each frame reordered as above.
- m_ready = 0 for 20 cycles while three frames are offered -> s_ready falls after 16 accepted samples; m_valid and m_re = 0 are held stable; after release, all 24 outputs arrive in correct order with nothing dropped.
- Random s_valid/m_ready toggling (50%) over 100 frames -> output sequence matches a bit-reverse reference model; m_last count = 100.
- arst_n asserted after 5 samples of frame 2 -> all outputs 0 immediately; post-reset frame 0..7 gives 0,4,2,6,1,5,3,7 with no stale data.
- BYPASS = 1 with input 0..7 -> output 0..7 in order; latency and handshake timing identical to BYPASS = 0.

Source files
------------

// File: rtl/fft_reorder_8p.sv
// ---------------------------------------------------------------------------
// fft_reorder_8p
// Output-side reorder buffer for the FFT datapath. Samples arrive in
// bit-reversed index order and leave in natural index order. Two ping-pong
// banks let one frame be written while the previous one drains, so streaming
// at one sample per cycle has no bubbles.
//
// Ports:
//   clk      in   clock
//   arst_n   in   asynchronous active-low reset
//   s_valid  in   input sample valid
//   s_ready  out  input sample can be accepted (combinational from state)
//   s_re     in   input real part, signed
//   s_im     in   input imaginary part, signed
//   m_valid  out  output sample valid (registered)
//   m_ready  in   downstream accepts output sample
//   m_re     out  output real part, signed (registered)
//   m_im     out  output imaginary part, signed (registered)
//   m_last   out  marks output index N-1 of each frame (registered)
// ---------------------------------------------------------------------------
module fft_reorder_8p #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N          = 8,
  parameter bit          BYPASS     = 1'b0
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_re,
  input  logic signed [DATA_WIDTH-1:0] s_im,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_WIDTH-1:0] m_re,
  output logic signed [DATA_WIDTH-1:0] m_im,
  output logic                         m_last
);

  localparam int unsigned LOG2N = (N > 1) ? $clog2(N) : 1;
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

  // Frame length must be a power of two of at least 2.
  if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("fft_reorder_8p: N must be a power of two >= 2");
  end

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } sample_t;

  // Reverse the bit order of an index.
  function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  sample_t          r_mem [2][N];
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [LOG2N-1:0] r_wr_cnt;
  logic [LOG2N-1:0] r_rd_cnt;
  logic [1:0]       r_full;
  logic             r_m_valid;
  logic             r_m_last;
  sample_t          r_m_data;

  logic             w_wr_fire;
  logic             w_wr_wrap;
  logic             w_load;
  logic             w_rd_wrap;
  logic [LOG2N-1:0] w_waddr;
  logic [1:0]       w_full_nxt;
  sample_t          w_rd_data;

  // Write side: a bank is writable until its frame is complete.
  assign s_ready   = !r_full[r_wr_bank];
  assign w_wr_fire = s_valid && s_ready;
  assign w_wr_wrap = w_wr_fire && (r_wr_cnt == CNT_LAST);
  assign w_waddr   = BYPASS ? r_wr_cnt : f_bitrev(r_wr_cnt);

  // Read side: refill the output register when it is empty or being consumed.
  assign w_rd_data = r_mem[r_rd_bank][r_rd_cnt];
  assign w_load    = r_full[r_rd_bank] && (!r_m_valid || m_ready);
  assign w_rd_wrap = w_load && (r_rd_cnt == CNT_LAST);

  // Bank occupancy; set and clear in one cycle always hit different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_wrap) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
    if (w_wr_wrap) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
  end

  // Sample storage, not reset.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_bank][w_waddr] <= sample_t'{re: s_re, im: s_im};
    end
  end

  // Write pointer and bank select.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else if (w_wr_fire) begin
      if (w_wr_wrap) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_wr_cnt  <= r_wr_cnt + LOG2N'(1);
      end
    end
  end

  // Bank full flags.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_full <= '0;
    end else begin
      r_full <= w_full_nxt;
    end
  end

  // Read pointer, bank select and output register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
    end else if (w_load) begin
      r_m_data  <= w_rd_data;
      r_m_last  <= (r_rd_cnt == CNT_LAST);
      r_m_valid <= 1'b1;
      if (w_rd_wrap) begin
        r_rd_cnt  <= '0;
        r_rd_bank <= ~r_rd_bank;
      end else begin
        r_rd_cnt  <= r_rd_cnt + LOG2N'(1);
      end
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign m_re    = r_m_data.re;
  assign m_im    = r_m_data.im;

endmodule
